spi_xfer_ctrl: RTL

- Transfer sequencer for the SPI master. Sits between the TX FIFO, the SPI pins and the RX FIFO.
- Pops bytes from the TX FIFO, shifts them out in SPI mode 0 (CPOL=0, CPHA=0) and pushes each received byte into the RX FIFO.
- Holds chip-select low across back-to-back bytes while TX data remains.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_gen.sv | 51 +++++
 rtl/spi_xfer_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer sequencer.
//   xfer_state_t : sequencer FSM states
//   SPI_DATA_W   : default SPI word width
//   bit_cnt_w()  : width of a counter that must hold 0..data_w
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    PUSH,
    NEXT,
    GAP
  } xfer_state_t;

  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator.
// While run_i is high a counter steps 0..CLK_DIV-1 and tick_o pulses for one
// cycle on the last count. When toggle_i is also high the tick flips sclk_o,
// and rise_o / fall_o flag which kind of edge that tick produces.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   run_i             : counter runs (counter held at 0 otherwise)
//   toggle_i          : ticks toggle sclk_o
//   tick_o            : one-cycle pulse every CLK_DIV running cycles
//   rise_o, fall_o    : tick that drives sclk_o 0->1 / 1->0
//   sclk_o            : registered SPI clock level
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic toggle_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] CntMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;

  always_comb begin
    tick_o = run_i && (cnt_q == CntMax);
    rise_o = tick_o && toggle_i && !sclk_q;
    fall_o = tick_o && toggle_i && sclk_q;
    cnt_d  = (!run_i || tick_o) ? '0 : cnt_q + 1'b1;
    sclk_d = sclk_q ^ (tick_o && toggle_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 transfer sequencer between TX FIFO, SPI pins and RX FIFO.
// Pops a word from the TX FIFO, shifts it out on mosi while sampling miso,
// pushes the received word into the RX FIFO, and keeps cs_n low across
// back-to-back words while enable is high and TX data remains.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input (sampled when
// a word is loaded); without it words are always MSB-first.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : allow bursts to start/continue
//   tx_empty, tx_rd_en,
//   tx_rd_data               : TX FIFO side (data valid cycle after tx_rd_en)
//   rx_full, rx_wr_en,
//   rx_wr_data               : RX FIFO side
//   sclk, mosi, miso, cs_n   : SPI pins (miso already synchronised)
//   busy                     : sequencer not in IDLE
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tx_empty,
  output logic              tx_rd_en,
  input  logic [DATA_W-1:0] tx_rd_data,
  input  logic              rx_full,
  output logic              rx_wr_en,
  output logic [DATA_W-1:0] rx_wr_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic              busy
`ifdef SPI_LSB_FIRST_EN
  ,
  input  logic              lsb_first
`endif
);

  localparam int unsigned   CntW    = bit_cnt_w(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam int unsigned   GapW    = $clog2(CS_GAP + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  xfer_state_t       state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              first_q, first_d;
  logic              lsb_q, lsb_d;
  logic              tx_rd_en_q, tx_rd_en_d;
  logic              rx_wr_en_q, rx_wr_en_d;
  logic [DATA_W-1:0] rx_wr_data_q, rx_wr_data_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;

  logic lsb_in;
  logic tick, rise, fall;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk_i   (clk),
    .rst_i   (rst),
    .run_i   ((state_q == SETUP) || (state_q == SHIFT)),
    .toggle_i(state_q == SHIFT),
    .tick_o  (tick),
    .rise_o  (rise),
    .fall_o  (fall),
    .sclk_o  (sclk)
  );

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    first_d      = first_q;
    lsb_d        = lsb_q;
    tx_rd_en_d   = 1'b0;
    rx_wr_en_d   = 1'b0;
    rx_wr_data_d = rx_wr_data_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;

    unique case (state_q)
      IDLE: begin
        if (enable && !tx_empty) begin
          tx_rd_en_d = 1'b1;
          first_d    = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // First LOAD cycle carries the read pulse; FIFO data is valid in the next one.
        if (!tx_rd_en_q) begin
          sh_d      = tx_rd_data;
          lsb_d     = lsb_in;
          mosi_d    = lsb_in ? tx_rd_data[0] : tx_rd_data[DATA_W-1];
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = first_q ? SETUP : SHIFT;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (rise) begin
          sh_d = lsb_q ? {miso, sh_q[DATA_W-1:1]} : {sh_q[DATA_W-2:0], miso};
        end else if (fall) begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            mosi_d    = lsb_q ? sh_q[0] : sh_q[DATA_W-1];
          end
        end
      end
      PUSH: begin
        if (!rx_full) begin
          rx_wr_en_d   = 1'b1;
          rx_wr_data_d = sh_q;
          state_d      = NEXT;
        end
      end
      NEXT: begin
        if (enable && !tx_empty) begin
          tx_rd_en_d = 1'b1;
          first_d    = 1'b0;
          state_d    = LOAD;
        end else begin
          cs_n_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GapLast) state_d = IDLE;
        else                      gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      first_q      <= 1'b0;
      lsb_q        <= 1'b0;
      tx_rd_en_q   <= 1'b0;
      rx_wr_en_q   <= 1'b0;
      rx_wr_data_q <= '0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      first_q      <= first_d;
      lsb_q        <= lsb_d;
      tx_rd_en_q   <= tx_rd_en_d;
      rx_wr_en_q   <= rx_wr_en_d;
      rx_wr_data_q <= rx_wr_data_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_rd_en   = tx_rd_en_q;
  assign rx_wr_en   = rx_wr_en_q;
  assign rx_wr_data = rx_wr_data_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;

endmodule
